// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the MIPS external-bus arbiter.
// Holds the arbiter FSM states, grant encoding and default bus widths.
package mips_bus_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  // Boot fetch address of the MIPS core.
  localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RDATA,
    DONE
  } state_t;

  typedef enum logic {
    GNT_M0,
    GNT_M1
  } grant_t;

  function automatic grant_t other_grant(input grant_t g);
    return (g == GNT_M0) ? GNT_M1 : GNT_M0;
  endfunction

endpackage

// File: rtl/mips_rr_picker.sv
// Combinational two-way request picker: round-robin against the last
// grant, or fixed priority with m1 winning when ROUND_ROBIN is 0.
module mips_rr_picker
  import mips_bus_pkg::*;
#(
  parameter int ROUND_ROBIN = 1
) (
  input  logic   req0,
  input  logic   req1,
  input  grant_t last_grant,
  output grant_t grant,
  output logic   valid
);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the block leaves a value unassigned and infers a latch.
  always_comb begin
    valid = req0 | req1;
    grant = GNT_M0;
    if (req0 && req1) begin
      grant = (ROUND_ROBIN != 0) ? other_grant(last_grant) : GNT_M1;
    end else if (req1) begin
      grant = GNT_M1;
    end
  end

endmodule

// File: rtl/mips_bus_arbiter.sv
// Two-master arbiter placing instruction fetch (m0) and load/store (m1)
// onto one external memory bus; all outputs are registered.
module mips_bus_arbiter
  import mips_bus_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int READ_LATENCY = 1,
  parameter int ROUND_ROBIN  = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_waitrequest,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_waitrequest,
  output logic [ADDR_W-1:0]   s_address,
  output logic                s_read,
  output logic                s_write,
  output logic [DATA_W-1:0]   s_writedata,
  output logic [DATA_W/8-1:0] s_byteenable,
  input  logic                s_waitrequest,
  input  logic [DATA_W-1:0]   s_readdata
);

  localparam int               CNT_W    = 2;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LATENCY - 1);

  state_t           state, state_next;
  grant_t           last_grant, winner, pick_grant;
  logic             pick_valid;
  logic             m0_req, m1_req;
  logic             accept;
  logic [CNT_W-1:0] cnt;

  assign m0_req = m0_read;
  assign m1_req = m1_read | m1_write;
  assign accept = (state == ISSUE) && (s_read || s_write) && !s_waitrequest;

  mips_rr_picker #(
    .ROUND_ROBIN(ROUND_ROBIN)
  ) u_picker (
    .req0      (m0_req),
    .req1      (m1_req),
    .last_grant(last_grant),
    .grant     (pick_grant),
    .valid     (pick_valid)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pick_valid) state_next = ISSUE;
      ISSUE:   if (accept) state_next = s_write ? DONE : RDATA;
      RDATA:   if (cnt == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bus and master-side registers; requests seen during DONE are ignored
  // because arbitration only happens from IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_address      <= '0;
      s_read         <= 1'b0;
      s_write        <= 1'b0;
      s_writedata    <= '0;
      s_byteenable   <= '0;
      m0_readdata    <= '0;
      m1_readdata    <= '0;
      m0_waitrequest <= 1'b1;
      m1_waitrequest <= 1'b1;
      last_grant     <= GNT_M1;
      winner         <= GNT_M0;
      cnt            <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            winner <= pick_grant;
            if (pick_grant == GNT_M1) begin
              // A simultaneous read+write from the data port is a write.
              s_address    <= m1_address;
              s_write      <= m1_write;
              s_read       <= !m1_write;
              s_writedata  <= m1_writedata;
              s_byteenable <= m1_byteenable;
            end else begin
              s_address    <= m0_address;
              s_read       <= 1'b1;
              s_write      <= 1'b0;
              s_writedata  <= '0;
              s_byteenable <= '1;
            end
          end
        end
        ISSUE: begin
          if (accept) begin
            s_read  <= 1'b0;
            s_write <= 1'b0;
            cnt     <= CNT_LOAD;
            if (s_write) begin
              if (winner == GNT_M0) m0_waitrequest <= 1'b0;
              else                  m1_waitrequest <= 1'b0;
            end
          end
        end
        RDATA: begin
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            if (winner == GNT_M0) begin
              m0_readdata    <= s_readdata;
              m0_waitrequest <= 1'b0;
            end else begin
              m1_readdata    <= s_readdata;
              m1_waitrequest <= 1'b0;
            end
          end
        end
        DONE: begin
          m0_waitrequest <= 1'b1;
          m1_waitrequest <= 1'b1;
          last_grant     <= winner;
        end
        default: ;
      endcase
    end
  end

endmodule
